// File: rtl/FIFO_pkg.sv
// FIFO_pkg: shared FIFO width, reader FSM states and skid depth default.
package FIFO_pkg;
  localparam int FIFO_WIDTH = 16;
  localparam int SKID_DEPTH_DEF = 2;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} reader_state_e;
endpackage

// File: rtl/fifo_reader_skid_buf.sv
// fifo_reader_skid_buf: circular skid buffer with occupancy count and head-entry output.
module fifo_reader_skid_buf #(
  parameter int W = 16,
  parameter int D = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push_i,
  input  logic                 pop_i,
  input  logic [W-1:0]         din_i,
  output logic [$clog2(D):0]   occ_o,
  output logic [W-1:0]         dout_o
);
  localparam int AW = $clog2(D);
  logic [W-1:0]  mem_q [D];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0]   occ_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < D; i++) mem_q[i] <= '0;
      wp_q  <= '0;
      rp_q  <= '0;
      occ_q <= '0;
    end else begin
      if (push_i) mem_q[wp_q] <= din_i;
      wp_q  <= wp_q + AW'(push_i);
      rp_q  <= rp_q + AW'(pop_i);
      occ_q <= occ_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
    end
  end
  assign occ_o  = occ_q;
  assign dout_o = mem_q[rp_q];
endmodule

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: pops a registered-read FIFO into a skid buffer and presents a valid/ready stream.
// Define FIFO_READER_STATS_EN to build the saturating word/stall counters; otherwise they read 0.
module fifo_stream_reader #(
  parameter int FIFO_WIDTH = FIFO_pkg::FIFO_WIDTH,
  parameter int SKID_DEPTH = FIFO_pkg::SKID_DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [FIFO_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_empty,
  input  logic                  fifo_underflow,
  output logic                  fifo_rd_en,
  output logic [FIFO_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  busy,
  output logic                  err_underflow,
  output logic [31:0]           stat_words,
  output logic [31:0]           stat_stalls
);
  import FIFO_pkg::*;
  localparam int OW = $clog2(SKID_DEPTH) + 1;
  reader_state_e state_q, state_d;
  logic          inflight_q, err_q, push, pop, room, drained;
  logic [OW-1:0] occ;
  fifo_reader_skid_buf #(.W(FIFO_WIDTH), .D(SKID_DEPTH)) u_skid (
    .clk(clk), .rst_n(rst_n), .push_i(push), .pop_i(pop),
    .din_i(fifo_data_out), .occ_o(occ), .dout_o(m_data)
  );
  assign pop     = m_valid && m_ready;
  assign push    = inflight_q && !fifo_underflow;
  // A pop this cycle frees a slot, which keeps 1 word/cycle with a 2-entry buffer.
  assign room    = (occ + OW'(inflight_q)) < (OW'(SKID_DEPTH) + OW'(pop));
  assign drained = (occ == '0) && !inflight_q;
  assign fifo_rd_en    = rst_n && (state_q == RUN) && en && !fifo_empty && room;
  assign m_valid       = occ != '0;
  assign busy          = state_q != IDLE;
  assign err_underflow = err_q;
  always_comb begin
    state_d = state_q;
    state_d = en ? RUN : ((state_q == IDLE) || drained) ? IDLE : DRAIN;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      inflight_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= fifo_rd_en;
      err_q      <= err_q | (inflight_q & fifo_underflow);
    end
  end
`ifdef FIFO_READER_STATS_EN
  logic [31:0] words_q, stalls_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      words_q  <= '0;
      stalls_q <= '0;
    end else begin
      words_q  <= words_q + 32'(pop && (words_q != '1));
      stalls_q <= stalls_q + 32'(m_valid && !m_ready && (stalls_q != '1));
    end
  end
  assign stat_words  = words_q;
  assign stat_stalls = stalls_q;
`else
  assign stat_words  = '0;
  assign stat_stalls = '0;
`endif
endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader: directed scenarios against a small registered-read FIFO model.
module tb_fifo_stream_reader;
  import FIFO_pkg::*;
  localparam int W = 16;
  localparam int D = 2;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, m_ready = 1'b0, uf_inject = 1'b0;
  logic fifo_empty = 1'b1, fifo_underflow = 1'b0;
  logic [W-1:0] fifo_data_out = '0;
  logic fifo_rd_en, m_valid, busy, err_underflow;
  logic [W-1:0] m_data;
  logic [31:0] stat_words, stat_stalls;
  int checks = 0, failures = 0, rd_cnt = 0;
  logic [W-1:0] q[$];
  logic [W-1:0] rx[$];
  fifo_stream_reader #(.FIFO_WIDTH(W), .SKID_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .fifo_data_out(fifo_data_out),
    .fifo_empty(fifo_empty), .fifo_underflow(fifo_underflow), .fifo_rd_en(fifo_rd_en),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .busy(busy),
    .err_underflow(err_underflow), .stat_words(stat_words), .stat_stalls(stat_stalls)
  );
  always #5 clk = ~clk;
  // FIFO model: registered read data and registered empty flag
  always @(posedge clk) begin
    fifo_underflow <= fifo_rd_en && uf_inject;
    if (fifo_rd_en) begin
      fifo_data_out <= (q.size() > 0) ? q[0] : 16'hDEAD;
      if (q.size() > 0) q.pop_front();
    end
    fifo_empty <= (q.size() == 0);
  end
  always @(negedge clk) begin
    if (rst_n && m_valid && m_ready) rx.push_back(m_data);
    if (fifo_rd_en) rd_cnt++;
    if (rst_n && (32'(dut.occ) + 32'(dut.inflight_q) > D)) begin
      failures++;
      $display("FAIL skid_overflow occ=%0d inflight=%0b limit=%0d", dut.occ, dut.inflight_q, D);
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic apply_reset;
    rst_n = 1'b0; en = 1'b0; m_ready = 1'b0; uf_inject = 1'b0;
    q.delete();
    tick; tick;
    rst_n = 1'b1;
    tick;
    rx.delete();
    rd_cnt = 0;
  endtask
  task automatic wait_idle(input string name);
    for (int i = 0; i < 20 && busy; i++) tick;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL %s_idle busy=%0b exp=0", name, busy); end
  endtask
  task automatic test_reset;
    rst_n = 1'b0; en = 1'b0; m_ready = 1'b0;
    tick; tick;
    checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL reset_m_valid got=%0b exp=0", m_valid); end
    checks++; if (m_data !== 16'h0) begin failures++; $display("FAIL reset_m_data got=%h exp=0000", m_data); end
    checks++; if (fifo_rd_en !== 1'b0) begin failures++; $display("FAIL reset_rd_en got=%0b exp=0", fifo_rd_en); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if (err_underflow !== 1'b0) begin failures++; $display("FAIL reset_err got=%0b exp=0", err_underflow); end
    checks++; if (stat_words !== 32'd0 || stat_stalls !== 32'd0) begin failures++; $display("FAIL reset_stats words=%0d stalls=%0d exp=0/0", stat_words, stat_stalls); end
    apply_reset;
  endtask
  task automatic test_basic;
    rd_cnt = 0; rx.delete();
    q = '{16'hA1, 16'hB2, 16'hC3};
    en = 1'b1; m_ready = 1'b1;
    tick;
    checks++; if (fifo_rd_en !== 1'b1) begin failures++; $display("FAIL basic_rd1 got=%0b exp=1", fifo_rd_en); end
    tick;
    checks++; if (fifo_rd_en !== 1'b1 || m_valid !== 1'b0) begin failures++; $display("FAIL basic_c2 rd=%0b valid=%0b exp=1/0", fifo_rd_en, m_valid); end
    tick;
    checks++; if (m_valid !== 1'b1 || m_data !== 16'hA1) begin failures++; $display("FAIL basic_A1 valid=%0b data=%h exp=1/a1", m_valid, m_data); end
    checks++; if (fifo_rd_en !== 1'b1) begin failures++; $display("FAIL basic_rd3 got=%0b exp=1", fifo_rd_en); end
    tick;
    checks++; if (m_valid !== 1'b1 || m_data !== 16'hB2) begin failures++; $display("FAIL basic_B2 valid=%0b data=%h exp=1/b2", m_valid, m_data); end
    tick;
    checks++; if (m_valid !== 1'b1 || m_data !== 16'hC3) begin failures++; $display("FAIL basic_C3 valid=%0b data=%h exp=1/c3", m_valid, m_data); end
    tick;
    checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL basic_empty valid=%0b exp=0", m_valid); end
    en = 1'b0;
    tick;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy got=%0b exp=0", busy); end
    checks++; if (rd_cnt !== 3) begin failures++; $display("FAIL basic_rd_count got=%0d exp=3", rd_cnt); end
  endtask
  task automatic test_backpressure;
    logic [W-1:0] exp [5] = '{16'h11, 16'h22, 16'h33, 16'h44, 16'h55};
    rd_cnt = 0; rx.delete();
    q = '{16'h11, 16'h22, 16'h33, 16'h44, 16'h55};
    en = 1'b1; m_ready = 1'b0;
    repeat (6) tick;
    checks++; if (rd_cnt !== D || fifo_rd_en !== 1'b0) begin failures++; $display("FAIL bp_reads count=%0d rd=%0b exp=%0d/0", rd_cnt, fifo_rd_en, D); end
    checks++; if (m_valid !== 1'b1 || m_data !== 16'h11) begin failures++; $display("FAIL bp_hold valid=%0b data=%h exp=1/11", m_valid, m_data); end
    m_ready = 1'b1;
    repeat (12) tick;
    checks++; if (rx.size() !== 5) begin failures++; $display("FAIL bp_count got=%0d exp=5", rx.size()); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (rx.size() <= i || rx[i] !== exp[i]) begin failures++; $display("FAIL bp_word%0d got=%h exp=%h", i, (rx.size() > i) ? rx[i] : 16'hxxxx, exp[i]); end
    end
    en = 1'b0;
    wait_idle("bp");
  endtask
  task automatic test_drain;
    rx.delete();
    q = '{16'h66, 16'h77};
    en = 1'b1; m_ready = 1'b0;
    repeat (4) tick;
    en = 1'b0; rd_cnt = 0;
    tick;
    checks++; if (dut.state_q !== DRAIN || busy !== 1'b1) begin failures++; $display("FAIL drain_state got=%0d busy=%0b exp=%0d/1", dut.state_q, busy, DRAIN); end
    m_ready = 1'b1;
    wait_idle("drain");
    checks++; if (rx.size() !== 2 || rx[0] !== 16'h66 || rx[1] !== 16'h77) begin failures++; $display("FAIL drain_words count=%0d exp=2 words 66,77", rx.size()); end
    checks++; if (rd_cnt !== 0) begin failures++; $display("FAIL drain_no_read got=%0d exp=0", rd_cnt); end
  endtask
  task automatic test_reset_midflight;
    rx.delete();
    q = '{16'h81, 16'h82, 16'h83, 16'h84, 16'h85};
    en = 1'b1; m_ready = 1'b0;
    repeat (3) tick;
    checks++; if (m_valid !== 1'b1 || dut.inflight_q !== 1'b1) begin failures++; $display("FAIL mid_setup valid=%0b inflight=%0b exp=1/1", m_valid, dut.inflight_q); end
    rst_n = 1'b0; en = 1'b0;
    tick;
    checks++; if (m_valid !== 1'b0 || fifo_rd_en !== 1'b0) begin failures++; $display("FAIL mid_reset valid=%0b rd=%0b exp=0/0", m_valid, fifo_rd_en); end
    checks++; if (err_underflow !== 1'b0 || stat_words !== 32'd0 || stat_stalls !== 32'd0) begin failures++; $display("FAIL mid_reset_regs err=%0b words=%0d stalls=%0d exp=0", err_underflow, stat_words, stat_stalls); end
    q.delete();
    tick;
    rst_n = 1'b1; m_ready = 1'b1;
    repeat (4) tick;
    checks++; if (rx.size() !== 0 || m_valid !== 1'b0) begin failures++; $display("FAIL mid_leak words=%0d valid=%0b exp=0/0", rx.size(), m_valid); end
  endtask
  task automatic test_underflow;
    rx.delete();
    q = '{16'h99};
    uf_inject = 1'b1; en = 1'b1; m_ready = 1'b1;
    repeat (3) tick;
    checks++; if (err_underflow !== 1'b1 || m_valid !== 1'b0) begin failures++; $display("FAIL uf_flag err=%0b valid=%0b exp=1/0", err_underflow, m_valid); end
    uf_inject = 1'b0; en = 1'b0;
    repeat (5) tick;
    checks++; if (err_underflow !== 1'b1 || rx.size() !== 0) begin failures++; $display("FAIL uf_sticky err=%0b words=%0d exp=1/0", err_underflow, rx.size()); end
    apply_reset;
    checks++; if (err_underflow !== 1'b0) begin failures++; $display("FAIL uf_clear err=%0b exp=0", err_underflow); end
  endtask
  task automatic test_stats;
    logic [31:0] exp_w, exp_s;
`ifdef FIFO_READER_STATS_EN
    exp_w = 32'd10; exp_s = 32'd4;
`else
    exp_w = 32'd0; exp_s = 32'd0;
`endif
    rx.delete();
    for (int i = 1; i <= 10; i++) q.push_back(16'(16'h100 + i));
    en = 1'b1; m_ready = 1'b0;
    repeat (7) tick;
    m_ready = 1'b1;
    repeat (30) tick;
    checks++; if (rx.size() !== 10 || rx[0] !== 16'h101 || rx[9] !== 16'h10A) begin failures++; $display("FAIL stats_stream count=%0d exp=10 words 101..10a", rx.size()); end
    checks++; if (stat_words !== exp_w) begin failures++; $display("FAIL stats_words got=%0d exp=%0d", stat_words, exp_w); end
    checks++; if (stat_stalls !== exp_s) begin failures++; $display("FAIL stats_stalls got=%0d exp=%0d", stat_stalls, exp_s); end
    en = 1'b0;
    wait_idle("stats");
  endtask
  initial begin
    test_reset;
    test_basic;
    test_backpressure;
    test_drain;
    test_reset_midflight;
    test_underflow;
    test_stats;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
